timer_param: RTL

Parametrised successor to the traffic-light phase timer. It counts clock cycles from a start/clear strobe and flags a long timeout (phase end) and a short timeout (early-warning / minimum-green). Long and short limits are runtime-loadable registers. Additions over the first-generation timer: pause, abort, and an optional auto-reload (periodic) mode. It sits beside the traffic-light controller FSM, which drives sc/stop/en and consumes tl/ts/tl_pulse.

---
 rtl/timer_param_pkg.sv | 20 ++
 rtl/timer_cfg_regs.sv | 41 ++++
 rtl/timer_param.sv | 92 +++++++++
 3 files changed

// File: rtl/timer_param_pkg.sv
// rtl/timer_param_pkg.sv - shared state, config-select and default-limit definitions for the phase timer
package timer_param_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic CFG_TS = 1'b0;
  localparam logic CFG_TL = 1'b1;

  localparam int TL_DEF_C = 29;
  localparam int TS_DEF_C = 2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/timer_cfg_regs.sv
// rtl/timer_cfg_regs.sv - runtime-loadable long/short limit registers with reset defaults
module timer_cfg_regs
  import timer_param_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int TL_DEF = TL_DEF_C,
  parameter int TS_DEF = TS_DEF_C
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cfg_we,
  input  logic             i_cfg_sel,
  input  logic [WIDTH-1:0] i_cfg_wdata,
  output logic [WIDTH-1:0] o_tl_lim,
  output logic [WIDTH-1:0] o_ts_lim
);

  localparam logic [WIDTH-1:0] TL_RST = WIDTH'(TL_DEF);
  localparam logic [WIDTH-1:0] TS_RST = WIDTH'(TS_DEF);

  logic [WIDTH-1:0] r_tl_lim;
  logic [WIDTH-1:0] r_ts_lim;

  // Writes bypass the counter's stop/sc priority and always land.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tl_lim <= TL_RST;
      r_ts_lim <= TS_RST;
    end else if (i_cfg_we) begin
      case (i_cfg_sel)
        CFG_TL:  r_tl_lim <= i_cfg_wdata;
        CFG_TS:  r_ts_lim <= i_cfg_wdata;
        default: ;
      endcase
    end
  end

  assign o_tl_lim = r_tl_lim;
  assign o_ts_lim = r_ts_lim;

endmodule

// File: rtl/timer_param.sv
// rtl/timer_param.sv - phase timer with loadable limits, pause, abort and optional periodic reload
module timer_param
  import timer_param_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int TL_DEF = TL_DEF_C,
  parameter int TS_DEF = TS_DEF_C,
  parameter int RELOAD = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sc,
  input  logic             i_stop,
  input  logic             i_en,
  input  logic             i_cfg_we,
  input  logic             i_cfg_sel,
  input  logic [WIDTH-1:0] i_cfg_wdata,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_busy,
  output logic             o_tl,
  output logic             o_ts,
  output logic             o_tl_pulse
);

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic             r_tl_q;

  logic [WIDTH-1:0] w_tl_lim;
  logic [WIDTH-1:0] w_ts_lim;
  logic             w_at_lim;
  logic             w_tl;
  logic [WIDTH-1:0] w_cnt_inc;

  timer_cfg_regs #(
    .WIDTH (WIDTH),
    .TL_DEF(TL_DEF),
    .TS_DEF(TS_DEF)
  ) u_cfg (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_cfg_we   (i_cfg_we),
    .i_cfg_sel  (i_cfg_sel),
    .i_cfg_wdata(i_cfg_wdata),
    .o_tl_lim   (w_tl_lim),
    .o_ts_lim   (w_ts_lim)
  );

  assign w_at_lim  = (r_cnt >= w_tl_lim);
  // Only used while r_cnt < tl_lim, so it cannot wrap.
  assign w_cnt_inc = r_cnt + WIDTH'(1);
  assign w_tl      = (r_state != S_IDLE) && w_at_lim;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tl_q  <= 1'b0;
    end else begin
      r_tl_q <= w_tl;
      if (i_stop) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else if (i_sc) begin
        r_state <= S_RUN;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_RUN: begin
            if (w_at_lim) begin
              if (RELOAD == 0) begin
                r_state <= S_DONE;
              end else if (i_en) begin
                r_cnt <= '0;
              end
            end else if (i_en) begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_cnt      = r_cnt;
  assign o_busy     = (r_state == S_RUN);
  assign o_tl       = w_tl;
  assign o_ts       = (r_state != S_IDLE) && (r_cnt == w_ts_lim);
  assign o_tl_pulse = w_tl && !r_tl_q;

endmodule
